// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 serializer: FSM states, default
// timing for 10 MHz and 12 MHz clocks, and the on-wire colour order.
package ws2812_pkg;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, LATCH} state_e;

    localparam int unsigned PIX_BITS = 24;

    localparam int unsigned T_BIT_10M   = 13;
    localparam int unsigned T0H_10M     = 4;
    localparam int unsigned T1H_10M     = 8;
    localparam int unsigned T_RESET_10M = 500;

    localparam int unsigned T_BIT_12M   = 15;
    localparam int unsigned T0H_12M     = 4;
    localparam int unsigned T1H_12M     = 9;
    localparam int unsigned T_RESET_12M = 600;

    typedef enum logic [1:0] {CH_R, CH_G, CH_B} chan_e;

    // Channel sent first on the wire is entry 0.
    localparam chan_e WIRE_ORDER [3] = '{CH_G, CH_R, CH_B};

    function automatic logic [PIX_BITS-1:0] to_wire(input logic [PIX_BITS-1:0] rgb);
        logic [PIX_BITS-1:0] w;
        logic [7:0]          c;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            case (WIRE_ORDER[i])
                CH_R:    c = rgb[23:16];
                CH_G:    c = rgb[15:8];
                default: c = rgb[7:0];
            endcase
            w[PIX_BITS-1-8*i -: 8] = c;
        end
        return w;
    endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Single WS2812 bit-period generator: a start pulse launches one T_BIT-cycle
// period whose high time depends on the bit value; done marks its last cycle.
module ws2812_bit_tx #(
    parameter int unsigned T_BIT = 13,
    parameter int unsigned T0H   = 4,
    parameter int unsigned T1H   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic bit_i,
    output logic dout_o,
    output logic done_o
);

    localparam int unsigned CW = $clog2(T_BIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] high_len;
    logic          active_q, active_d;
    logic          bit_q, bit_d;
    logic          dout_q, dout_d;

    // done is decoded from registered state so the next start lands back-to-back.
    always_comb begin
        high_len = bit_q ? CW'(T1H) : CW'(T0H);
        done_o   = active_q && (cnt_q == CW'(T_BIT - 1));
        cnt_d    = cnt_q;
        active_d = active_q;
        bit_d    = bit_q;
        dout_d   = dout_q;
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = '0;
            bit_d    = bit_i;
            dout_d   = 1'b1;
        end else if (done_o) begin
            active_d = 1'b0;
            cnt_d    = '0;
            dout_d   = 1'b0;
        end else if (active_q) begin
            cnt_d  = cnt_q + CW'(1);
            dout_d = (cnt_q + CW'(1)) < high_len;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            bit_q    <= 1'b0;
            dout_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            bit_q    <= bit_d;
            dout_q   <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/ws2812_serializer.sv
// Frames NUM_LEDS RGB pixels from a valid/ready stream onto a WS2812 data line,
// followed by a latch gap; flags an underrun if the source stalls mid-frame.
module ws2812_serializer
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned T_BIT    = T_BIT_10M,
    parameter int unsigned T0H      = T0H_10M,
    parameter int unsigned T1H      = T1H_10M,
    parameter int unsigned T_RESET  = T_RESET_10M
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PIX_BITS-1:0] rgb_in,
    input  logic                rgb_valid,
    output logic                rgb_ready,
    output logic                dout,
    output logic                busy,
    output logic                frame_done,
    output logic                underrun
);

    localparam int unsigned PCW = $clog2(NUM_LEDS + 1);
    localparam int unsigned GW  = $clog2(T_RESET);
    localparam int unsigned BW  = 5;

    state_e              state_q, state_d;
    logic [PIX_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]       bit_idx_q, bit_idx_d;
    logic                first_q, first_d;
    logic [PCW-1:0]      pix_cnt_q, pix_cnt_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                frame_done_q, frame_done_d;
    logic                underrun_q, underrun_d;
    logic                busy_q;
    logic                alive_q;
    logic                transfer;
    logic                tx_start;
    logic                tx_done;

    // alive_q holds ready low until the first clock after reset release.
    assign rgb_ready = alive_q && (state_q == IDLE || state_q == WAIT);
    assign transfer  = rgb_valid && rgb_ready;

    ws2812_bit_tx #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_bit_tx (
        .clk     (clk),
        .reset   (reset),
        .start_i (tx_start),
        .bit_i   (shift_q[PIX_BITS-1]),
        .dout_o  (dout),
        .done_o  (tx_done)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        first_d      = first_q;
        pix_cnt_d    = pix_cnt_q;
        gap_d        = gap_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        tx_start     = 1'b0;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d   = SEND;
                    pix_cnt_d = '0;
                end
            end
            SEND: begin
                if (first_q) begin
                    tx_start = 1'b1;
                    first_d  = 1'b0;
                    shift_d  = shift_q << 1;
                end else if (tx_done) begin
                    if (bit_idx_q == BW'(PIX_BITS - 1)) begin
                        pix_cnt_d = pix_cnt_q + PCW'(1);
                        gap_d     = '0;
                        state_d   = (pix_cnt_d == PCW'(NUM_LEDS)) ? LATCH : WAIT;
                    end else begin
                        tx_start  = 1'b1;
                        bit_idx_d = bit_idx_q + BW'(1);
                        shift_d   = shift_q << 1;
                    end
                end
            end
            WAIT: begin
                // A transfer on the timeout cycle keeps the frame alive.
                if (transfer) begin
                    state_d = SEND;
                end else if (gap_q == GW'(T_RESET - 1)) begin
                    underrun_d = 1'b1;
                    pix_cnt_d  = '0;
                    gap_d      = '0;
                    state_d    = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            LATCH: begin
                if (gap_q == GW'(T_RESET - 1)) begin
                    frame_done_d = 1'b1;
                    pix_cnt_d    = '0;
                    gap_d        = '0;
                    state_d      = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Pixel capture is common to IDLE and WAIT.
        if (transfer) begin
            shift_d   = to_wire(rgb_in);
            bit_idx_d = '0;
            first_d   = 1'b1;
            gap_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            first_q      <= 1'b0;
            pix_cnt_q    <= '0;
            gap_q        <= '0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            busy_q       <= 1'b0;
            alive_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            first_q      <= first_d;
            pix_cnt_q    <= pix_cnt_d;
            gap_q        <= gap_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
            busy_q       <= (state_d != IDLE);
            alive_q      <= 1'b1;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_ws2812_serializer.sv
// Randomized bench for ws2812_serializer: a timestamp model predicts every bit
// edge, handshake level and pulse; monitors decode the line and compare.
module tb_ws2812_serializer;

    localparam int unsigned NUM_LEDS = 2;
    localparam int unsigned T_BIT    = 13;
    localparam int unsigned T0H      = 4;
    localparam int unsigned T1H      = 8;
    localparam int unsigned T_RESET  = 500;
    localparam int          PIX      = 24;
    localparam int          BIG      = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] rgb_in = '0;
    logic        rgb_valid = 1'b0;
    logic        rgb_ready, dout, busy, frame_done, underrun;

    ws2812_serializer #(
        .NUM_LEDS (NUM_LEDS),
        .T_BIT    (T_BIT),
        .T0H      (T0H),
        .T1H      (T1H),
        .T_RESET  (T_RESET)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rgb_in     (rgb_in),
        .rgb_valid  (rgb_valid),
        .rgb_ready  (rgb_ready),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    typedef struct { int start; int high; } bit_exp_t;

    bit_exp_t    exp_bits[$];
    int          exp_done[$];
    int          exp_under[$];
    logic [23:0] stim_q[$];

    // Model state, all in absolute clock-edge numbers.
    bit model_en   = 1'b0;
    int ready_from = BIG;
    int busy_from  = 0;
    int busy_until = 0;
    int count      = 0;
    bit pend       = 1'b0;
    int deadline   = 0;
    int last_n     = 0;

    task automatic drive_inputs();
        rgb_valid = (stim_q.size() != 0);
        rgb_in    = rgb_valid ? stim_q[0] : 24'($urandom);
    endtask

    task automatic model_tick();
        int          c, n, e;
        logic [23:0] px, w;
        c = cyc;
        check("ready", rgb_ready, 32'(c >= ready_from));
        check("busy", busy, 32'(c >= busy_from && c < busy_until));
        if (rgb_valid && c >= ready_from) begin
            px = stim_q.pop_front();
            n  = c + 1;
            e  = n + 1 + PIX * T_BIT;
            last_n = n;
            w = {px[15:8], px[23:16], px[7:0]};
            for (int k = 0; k < PIX; k++)
                exp_bits.push_back('{n + 1 + k * T_BIT, w[PIX-1-k] ? int'(T1H) : int'(T0H)});
            if (count == 0) busy_from = n;
            pend = 1'b0;
            count++;
            if (count == NUM_LEDS) begin
                count      = 0;
                exp_done.push_back(e + T_RESET);
                ready_from = e + T_RESET;
                busy_until = e + T_RESET;
            end else begin
                pend       = 1'b1;
                deadline   = e + T_RESET;
                ready_from = e;
                busy_until = BIG;
            end
        end else if (pend && c + 1 == deadline) begin
            pend       = 1'b0;
            count      = 0;
            exp_under.push_back(deadline);
            busy_until = deadline;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (model_en) model_tick();
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic send(input logic [23:0] p);
        stim_q.push_back(p);
        drive_inputs();
    endtask

    task automatic wait_sent();
        int guard = 0;
        while (stim_q.size() != 0 && guard < 5000) begin
            step();
            guard++;
        end
        check("send_timeout", stim_q.size(), 0);
    endtask

    task automatic wait_quiet();
        wait_sent();
        if (pend) wait_until(deadline + 2);
        else      wait_until(ready_from + 2);
    endtask

    // Line and pulse monitor.
    initial begin
        bit       prev = 1'b0;
        bit       in_high = 1'b0;
        int       hlen = 0;
        int       cur_high = 0;
        bit_exp_t b;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev    = 1'b0;
                in_high = 1'b0;
            end else begin
                if (dout && !prev) begin
                    if (exp_bits.size() == 0) begin
                        check("rise_unexpected", dout, 0);
                    end else begin
                        b = exp_bits.pop_front();
                        check("bit_start", cyc, b.start);
                        cur_high = b.high;
                        hlen     = 1;
                        in_high  = 1'b1;
                    end
                end else if (dout && prev) begin
                    hlen++;
                end else if (!dout && prev && in_high) begin
                    check("bit_high_len", hlen, cur_high);
                    in_high = 1'b0;
                end
                prev = dout;
                if (frame_done) begin
                    if (exp_done.size() == 0) check("frame_done_unexpected", frame_done, 0);
                    else                      check("frame_done_time", cyc, exp_done.pop_front());
                end
                if (underrun) begin
                    if (exp_under.size() == 0) check("underrun_unexpected", underrun, 0);
                    else                       check("underrun_time", cyc, exp_under.pop_front());
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 0);
        check("rst_ready", rgb_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_underrun", underrun, 0);
        reset      = 1'b0;
        ready_from = cyc + 1;
        model_en   = 1'b1;
        step();
        check("ready_after_reset", rgb_ready, 1);

        // Single red pixel; frame of two stays short, so it underruns.
        send(24'hFF0000);
        wait_quiet();

        // Fresh frame, two pixels back-to-back with valid held high.
        send(24'($urandom));
        send(24'($urandom));
        wait_quiet();

        // Second pixel arrives exactly on the timeout edge.
        send(24'($urandom));
        wait_sent();
        wait_until(deadline - 1);
        send(24'($urandom));
        wait_quiet();

        // One cycle too late: underrun, then the late pixel opens a new frame.
        send(24'($urandom));
        wait_sent();
        wait_until(deadline);
        send(24'($urandom));
        wait_quiet();

        for (int i = 0; i < 8; i++) begin
            send(24'($urandom));
            wait_sent();
            case ($urandom_range(0, 3))
                0: ;
                1: repeat ($urandom_range(1, 40)) step();
                2: if (pend) wait_until(deadline - int'($urandom_range(1, 3)));
                default: if (pend) wait_until(deadline + int'($urandom_range(0, 3)));
            endcase
        end
        wait_quiet();

        // Asynchronous reset in the high phase of bit 2.
        send(24'($urandom));
        wait_sent();
        wait_until(last_n + 1 + 2 * T_BIT + 2);
        check("dout_before_reset", dout, 1);
        #2;
        reset    = 1'b1;
        model_en = 1'b0;
        #1;
        check("dout_async_reset", dout, 0);
        check("ready_in_reset", rgb_ready, 0);
        check("busy_in_reset", busy, 0);
        exp_bits.delete();
        exp_done.delete();
        exp_under.delete();
        stim_q.delete();
        count      = 0;
        pend       = 1'b0;
        busy_from  = 0;
        busy_until = 0;
        repeat (3) step();
        reset      = 1'b0;
        ready_from = cyc + 1;
        model_en   = 1'b1;
        step();
        check("ready_after_midreset", rgb_ready, 1);
        check("busy_after_midreset", busy, 0);

        send(24'($urandom));
        send(24'($urandom));
        wait_quiet();
        repeat (5) step();

        check("bits_outstanding", exp_bits.size(), 0);
        check("frame_done_outstanding", exp_done.size(), 0);
        check("underrun_outstanding", exp_under.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
